// File: rtl/add_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
//   NIBBLE_W      : width of the shared arithmetic slice
//   state_t       : sequencer state encoding (IDLE, RUN, DONE)
//   nibble_count  : number of slice passes for a given operand width
//   index_width   : bits needed for the nibble index (minimum 1)
package add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

    function automatic int index_width(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Requester-side bus of the add/subtract sequencer.
//   start, sub, a, b, c_in : request and operands (requester -> sequencer)
//   busy, done, sum, c_out : status and result (sequencer -> requester)
//
// Handshake: start is a request that is accepted on the rising edge where
// busy is low (sequencer idle). While busy is high start is ignored and not
// queued. done pulses for one cycle; sum/c_out are valid while done is high
// and hold until nibble 0 of the next accepted request is written.
interface add_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    modport master (
        output start, sub, a, b, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, sub, a, b, c_in,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/add_4.sv
// 4-bit ripple-carry adder slice, purely combinational.
//   a, b  : 4-bit operands
//   c_in  : carry into bit 0
//   sum   : 4-bit sum
//   c_out : carry out of bit 3
module add_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        c_out = c[4];
    end
endmodule

// File: rtl/add_seq_ctrl.sv
// WIDTH-bit add/subtract computed over WIDTH/4 cycles on one add_4 slice,
// least-significant nibble first, carry held in a register between passes.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : slave side of add_seq_ctrl_if (start/sub/a/b/c_in in,
//              busy/done/sum/c_out out)
//   state_o  : current sequencer state, for observation
module add_seq_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    add_seq_ctrl_if.slave bus,
    output state_t        state_o
);
    localparam int NIBBLES = nibble_count(WIDTH);
    localparam int IDX_W   = index_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
            $error("add_seq_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, slice_sum;
    logic                slice_cout;

    add_4 u_slice (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_cout)
    );

    // Operand nibble select for the current pass.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == i[IDX_W-1:0]) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtract is a + ~b + 1, so invert b here and force the carry.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == i[IDX_W-1:0]) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // Index is left at its final value so it never wraps.
                    c_out_d = slice_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
module tb_add_seq_ctrl;
    import add_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    add_seq_ctrl_if #(.WIDTH(16)) i16 ();
    add_seq_ctrl_if #(.WIDTH(4))  i4 ();
    state_t st16, st4;

    add_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .bus     (i16.slave),
        .state_o (st16)
    );

    add_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .bus     (i4.slave),
        .state_o (st4)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Subtract carry means "a >= b" (no borrow).
    function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        int unsigned r;
        if (sub) begin
            r = (int'(a) - int'(b)) & 32'hFFFF;
            return {(a >= b), r[15:0]};
        end
        r = int'(a) + int'(b) + int'(cin);
        return r[16:0];
    endfunction

    function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin, input logic sub);
        int unsigned r;
        if (sub) begin
            r = (int'(a) - int'(b)) & 32'hF;
            return {(a >= b), r[3:0]};
        end
        r = int'(a) + int'(b) + int'(cin);
        return r[4:0];
    endfunction

    // ---------------- drivers ----------------
    // Called at a negedge; returns at the negedge after the done cycle (IDLE).
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tcin, input logic tsub, input bit poke);
        logic [16:0] e;
        int cyc;
        bit seen;
        i16.start = 1'b1;
        i16.a     = ta;
        i16.b     = tb_v;
        i16.c_in  = tcin;
        i16.sub   = tsub;
        exp_q.push_back(model16(ta, tb_v, tcin, tsub));
        @(posedge clk);
        @(negedge clk);
        cyc  = 1;
        seen = 0;
        while (cyc <= 20 && !seen) begin
            if (i16.done) begin
                seen = 1;
            end else begin
                check("busy16_run", i16.busy, 1);
                if (poke && cyc == 2) begin
                    i16.start = 1'b1;
                    i16.a     = 16'hAAAA;
                    i16.b     = 16'h5555;
                end else begin
                    i16.start = 1'b0;
                    i16.a     = 16'($urandom);
                    i16.b     = 16'($urandom);
                    i16.sub   = 1'($urandom);
                    i16.c_in  = 1'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end
        i16.start = 1'b0;
        e = exp_q.pop_front();
        check("done16_seen", seen, 1);
        check("latency16", cyc, 5);
        check("busy16_done", i16.busy, 1);
        check("sum16", i16.sum, e[15:0]);
        check("c_out16", i16.c_out, e[16]);
        @(negedge clk);
        check("done16_pulse", i16.done, 0);
        check("busy16_idle", i16.busy, 0);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic tcin, input logic tsub);
        logic [4:0] e;
        int cyc;
        bit seen;
        i4.start = 1'b1;
        i4.a     = ta;
        i4.b     = tb_v;
        i4.c_in  = tcin;
        i4.sub   = tsub;
        e = model4(ta, tb_v, tcin, tsub);
        @(posedge clk);
        @(negedge clk);
        i4.start = 1'b0;
        cyc  = 1;
        seen = 0;
        while (cyc <= 10 && !seen) begin
            if (i4.done) seen = 1;
            else begin
                check("busy4_run", i4.busy, 1);
                @(negedge clk);
                cyc++;
            end
        end
        check("done4_seen", seen, 1);
        check("latency4", cyc, 2);
        check("sum4", i4.sum, e[3:0]);
        check("c_out4", i4.c_out, e[4]);
        @(negedge clk);
        check("done4_pulse", i4.done, 0);
        check("busy4_idle", i4.busy, 0);
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst = 1'b1;
        i16.start = 0; i16.sub = 0; i16.a = '0; i16.b = '0; i16.c_in = 0;
        i4.start  = 0; i4.sub  = 0; i4.a  = '0; i4.b  = '0; i4.c_in  = 0;
        repeat (2) @(negedge clk);
        check("rst_state16", st16, IDLE);
        check("rst_busy16", i16.busy, 0);
        check("rst_done16", i16.done, 0);
        check("rst_sum16", i16.sum, 0);
        check("rst_c_out16", i16.c_out, 0);
        check("rst_state4", st4, IDLE);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases; consecutive calls are back-to-back starts.
        run16(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
        run16(16'h00FF, 16'h0000, 1'b1, 1'b0, 0);
        run16(16'h1000, 16'h0001, 1'b1, 1'b1, 0);
        run16(16'h0001, 16'h0002, 1'b1, 1'b1, 0);
        run16(16'h1111, 16'h1111, 1'b0, 1'b0, 1);
        run16(16'h8000, 16'h8000, 1'b1, 1'b0, 0);
        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);

        // Reset during the second RUN cycle.
        i16.start = 1'b1; i16.sub = 1'b0; i16.a = 16'h1111; i16.b = 16'h1111; i16.c_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i16.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", i16.busy, 0);
        check("abort_done", i16.done, 0);
        check("abort_sum", i16.sum, 0);
        check("abort_c_out", i16.c_out, 0);
        check("abort_state", st16, IDLE);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_done", i16.done, 0);
        end
        run16(16'h2345, 16'h1111, 1'b0, 1'b1, 0);

        for (int k = 0; k < 30; k++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Single-nibble build.
        run4(4'hF, 4'h1, 1'b1, 1'b0);
        run4(4'h3, 4'h5, 1'b1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            run4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
